// File: rtl/sort_stream_unit.sv
// Streaming odd-even transposition sorter: load N words, run N compare-swap phases, drain in order.
// Build option: define SORT_DESCENDING_EN for non-increasing output order.
module sort_cmp_swap #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] first,
  output logic [W-1:0] second
);
  logic swap;
`ifdef SORT_DESCENDING_EN
  assign swap = a < b;
`else
  assign swap = a > b;
`endif
  assign first  = swap ? b : a;
  assign second = swap ? a : b;
endmodule

module sort_stream_unit #(
  parameter int W = 4,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         phase_even,
  output logic         phase_odd
);
  localparam int CW = $clog2(N) + 1;
  localparam int AW = $clog2(N);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       wr_ptr, rd_ptr, phase_cnt;
  logic [N-1:0][W-1:0] mem, mem_sorted;
  logic [N-2:0][W-1:0] pair_first, pair_second;
  logic                in_fire, out_fire, last_in, last_out, last_phase;

  // One comparator per adjacent pair; the phase parity picks which half is applied.
  genvar gi;
  generate
    for (gi = 0; gi < N - 1; gi++) begin : g_pair
      sort_cmp_swap #(.W(W)) u_cs (
        .a     (mem[gi]),
        .b     (mem[gi+1]),
        .first (pair_first[gi]),
        .second(pair_second[gi])
      );
    end
  endgenerate

  always_comb begin
    mem_sorted = mem;
    for (int p = 0; p < N - 1; p++) begin
      if ((p % 2) == int'(phase_cnt[0])) begin
        mem_sorted[p]   = pair_first[p];
        mem_sorted[p+1] = pair_second[p];
      end
    end
  end

  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign last_in    = (wr_ptr == CW'(N - 1));
  assign last_out   = (rd_ptr == CW'(N - 1));
  assign last_phase = (phase_cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    busy       = 1'b0;
    phase_even = 1'b0;
    phase_odd  = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_in) state_nxt = SORT;
      end
      SORT: begin
        busy       = 1'b1;
        phase_even = ~phase_cnt[0];
        phase_odd  = phase_cnt[0];
        if (last_phase) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = mem[rd_ptr[AW-1:0]];
        if (out_ready && last_out) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      phase_cnt <= '0;
      mem       <= '0;
    end else begin
      case (state)
        LOAD: if (in_fire) begin
          mem[wr_ptr[AW-1:0]] <= in_data;
          wr_ptr              <= last_in ? '0 : wr_ptr + CW'(1);
          if (last_in) phase_cnt <= '0;
        end
        SORT: begin
          mem       <= mem_sorted;
          phase_cnt <= last_phase ? '0 : phase_cnt + CW'(1);
          if (last_phase) rd_ptr <= '0;
        end
        DRAIN: if (out_fire) rd_ptr <= last_out ? '0 : rd_ptr + CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sort_stream_unit.sv
// Bench for sort_stream_unit: directed frames plus random frames against a plain sorting model.
module tb_sort_stream_unit;
  localparam int W = 4;
  localparam int N = 8;

  typedef logic [W-1:0] frame_t [N];

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         busy, phase_even, phase_odd;

  int checks = 0;
  int passes = 0;

  sort_stream_unit #(.W(W), .N(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy),
    .phase_even(phase_even), .phase_odd(phase_odd)
  );

  always #5 clk = ~clk;

  task automatic chk_b(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %b expected %b", tag, got, exp);
  endtask

  task automatic chk_w(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  // Reference: order the frame with a plain exchange sort.
  function automatic frame_t ref_sort(input frame_t f);
    frame_t r = f;
    logic [W-1:0] t;
    for (int a = 0; a < N; a++)
      for (int b = a + 1; b < N; b++) begin
`ifdef SORT_DESCENDING_EN
        if (r[b] > r[a]) begin t = r[a]; r[a] = r[b]; r[b] = t; end
`else
        if (r[b] < r[a]) begin t = r[a]; r[a] = r[b]; r[b] = t; end
`endif
      end
    return r;
  endfunction

  task automatic send_frame(input frame_t f, input bit gaps, input bit hold9);
    for (int k = 0; k < N; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        in_valid = 1'b0;
        chk_b("load_gap_ready", in_ready, 1'b1);
      end
      @(negedge clk);
      chk_b("load_ready", in_ready, 1'b1);
      chk_b("load_busy", busy, 1'b0);
      chk_b("load_out_valid", out_valid, 1'b0);
      in_valid = 1'b1;
      in_data  = f[k];
      @(posedge clk); #1;
    end
    in_valid = hold9;
    in_data  = hold9 ? 4'd9 : 4'd0;
  endtask

  task automatic check_sort();
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk_b("sort_busy", busy, 1'b1);
      chk_b("sort_in_ready", in_ready, 1'b0);
      chk_b("sort_out_valid", out_valid, 1'b0);
      chk_w("sort_out_data", out_data, 4'd0);
      chk_b("sort_phase_even", phase_even, (k % 2) == 0);
      chk_b("sort_phase_odd", phase_odd, (k % 2) == 1);
    end
  endtask

  // mode 0: always ready; 1: ready pattern 1,0,0 repeating; 2: random
  task automatic drain(input frame_t exp, input int mode);
    int   idx = 0;
    int   cyc = 0;
    logic r;
    while (idx < N && cyc < 200) begin
      @(negedge clk);
      cyc++;
      chk_b("drain_valid", out_valid, 1'b1);
      chk_b("drain_in_ready", in_ready, 1'b0);
      chk_b("drain_busy", busy, 1'b0);
      chk_w("drain_data", out_data, exp[idx]);
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3) == 1;
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      @(posedge clk); #1;
      if (r) idx++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (idx != N) chk_b("drain_timeout", 1'b0, 1'b1);
    @(negedge clk);
    chk_b("post_in_ready", in_ready, 1'b1);
    chk_b("post_out_valid", out_valid, 1'b0);
  endtask

  task automatic run_frame(input frame_t f, input bit gaps, input bit hold9, input int mode);
    send_frame(f, gaps, hold9);
    check_sort();
    drain(ref_sort(f), mode);
  endtask

  initial begin
    frame_t f;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_b("rst_in_ready", in_ready, 1'b1);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_w("rst_out_data", out_data, 4'd0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_phase_even", phase_even, 1'b0);
    chk_b("rst_phase_odd", phase_odd, 1'b0);
    reset = 1'b1;

    // Mixed frame, back-to-back load, always-ready drain (latency checked via check_sort + drain).
    f = '{4'd3, 4'd0, 4'd15, 4'd0, 4'd12, 4'd0, 4'd0, 4'd0};
    run_frame(f, 1'b0, 1'b0, 0);

    // Same frame drained with a stalling consumer.
    run_frame(f, 1'b0, 1'b0, 1);

    // Input held valid with 9 through SORT and DRAIN must not disturb the frame.
    f = '{4'd1, 4'd14, 4'd2, 4'd13, 4'd3, 4'd12, 4'd4, 4'd11};
    run_frame(f, 1'b0, 1'b1, 0);

    // Reset at SORT phase 3 drops the frame.
    f = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    send_frame(f, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk_b("pre_rst_phase_odd", phase_odd, 1'b1);
    reset = 1'b0;
    #1;
    chk_b("midrst_in_ready", in_ready, 1'b1);
    chk_b("midrst_out_valid", out_valid, 1'b0);
    chk_b("midrst_busy", busy, 1'b0);
    chk_b("midrst_phase_odd", phase_odd, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    f = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    run_frame(f, 1'b0, 1'b0, 0);

    // All-equal frame.
    f = '{default: 4'd5};
    run_frame(f, 1'b0, 1'b0, 2);

    // Random frames, with input gaps and random consumer stalls; some narrow-range for duplicates.
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < N; k++)
        f[k] = (n % 2 == 0) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 3));
      run_frame(f, 1'b1, 1'(n % 3 == 0), 2);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
